// File: rtl/gat_dbg_pkg.sv
// -----------------------------------------------------------------------------
// gat_dbg_pkg
// Shared types and constants for the GAT debug monitor.
//   dbg_state_e   : capture FSM encoding (IDLE=0, ARMED=1, DONE=2), which is
//                   also the encoding shown in the status word
//   W_*           : readout word indices for the fixed words. Channel counters
//                   start at W_CNT0, and capture slots follow the counters.
//   SIG_WORD_DEF  : default signature/version word
//   DEAD_WORD     : value returned for an out-of-range word select
//   rd_sel_w()    : width of the word-select bus for a given configuration
// -----------------------------------------------------------------------------
package gat_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } dbg_state_e;

    localparam int W_SIG    = 0;
    localparam int W_FLAGS  = 1;
    localparam int W_STATUS = 2;
    localparam int W_CYCLE  = 3;
    localparam int W_CNT0   = 4;

    localparam logic [31:0] SIG_WORD_DEF = 32'h0C47_0002;
    localparam logic [31:0] DEAD_WORD    = 32'hDEAD_BEEF;

    function automatic int rd_sel_w(input int num_ch, input int num_cap);
        return $clog2(4 + num_ch + num_cap);
    endfunction

endpackage

// File: rtl/gat_dbg_monitor_if.sv
// -----------------------------------------------------------------------------
// gat_dbg_monitor_if
// Bundles the probe inputs and the readout port of gat_dbg_monitor.
//   vld_i/rdy_i    : per-channel pipeline valid/ready being observed
//   clr_i, arm_i   : synchronous clear of statistics / (re)arm of capture
//   trig_*         : trigger address compare and qualifier
//   cap_data_i     : word captured on a qualified trigger
//   rd_sel_i       : readout word select
//   rd_data_o      : selected word
//   cap_done_o     : all capture slots filled
//   fsm_state_o    : live capture FSM state
// Readout protocol: there is no handshake. rd_sel_i is sampled on every clk
// edge and rd_data_o holds the selected word from the following edge on; the
// word shows the monitor state as it was just before that edge.
// Modports: master drives the probes and the select (SoC side / testbench),
// slave is the monitor itself.
// -----------------------------------------------------------------------------
interface gat_dbg_monitor_if
    import gat_dbg_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int NUM_CAP = 2,
    parameter int ADDR_W  = 14,
    parameter int DBG_W   = 32
);
    localparam int SEL_W = rd_sel_w(NUM_CH, NUM_CAP);

    logic [NUM_CH-1:0] vld_i;
    logic [NUM_CH-1:0] rdy_i;
    logic              clr_i;
    logic              arm_i;
    logic [ADDR_W-1:0] trig_match_i;
    logic [ADDR_W-1:0] trig_addr_i;
    logic              trig_qual_i;
    logic [DBG_W-1:0]  cap_data_i;
    logic [SEL_W-1:0]  rd_sel_i;
    logic [DBG_W-1:0]  rd_data_o;
    logic              cap_done_o;
    dbg_state_e        fsm_state_o;

    modport master (
        output vld_i, rdy_i, clr_i, arm_i, trig_match_i, trig_addr_i,
               trig_qual_i, cap_data_i, rd_sel_i,
        input  rd_data_o, cap_done_o, fsm_state_o
    );

    modport slave (
        input  vld_i, rdy_i, clr_i, arm_i, trig_match_i, trig_addr_i,
               trig_qual_i, cap_data_i, rd_sel_i,
        output rd_data_o, cap_done_o, fsm_state_o
    );

endinterface

// File: rtl/gat_dbg_sat_cnt.sv
// -----------------------------------------------------------------------------
// gat_dbg_sat_cnt
// Saturating event counter with a sticky overflow flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count this cycle
//   clr        : synchronous clear of cnt and ovf (wins over inc)
//   cnt        : current count, holds at all-ones
//   ovf        : set by an increment attempted at all-ones, held until clr
// -----------------------------------------------------------------------------
module gat_dbg_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (&cnt) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gat_dbg_monitor.sv
// -----------------------------------------------------------------------------
// gat_dbg_monitor
// On-chip debug monitor for the GAT accelerator pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gat_dbg_monitor_if.slave (probes, trigger, capture data,
//                readout select/data, cap_done_o, fsm_state_o)
// Keeps sticky valid/ready flags and saturating valid-cycle counters per
// channel, a free-running cycle counter, and NUM_CAP capture slots filled on
// qualified address-match triggers. Everything is read through one registered
// word-select port:
//   0 signature, 1 flags, 2 status, 3 cycle counter, 4.. channel counters,
//   then capture slots; any other select returns DEAD_WORD.
// clr_i clears the statistics only; capture slots and the FSM are untouched.
// -----------------------------------------------------------------------------
module gat_dbg_monitor
    import gat_dbg_pkg::*;
#(
    parameter int               NUM_CH   = 8,
    parameter int               NUM_CAP  = 2,
    parameter int               CNT_W    = 32,
    parameter int               ADDR_W   = 14,
    parameter int               DBG_W    = 32,
    parameter logic [DBG_W-1:0] SIG_WORD = DBG_W'(SIG_WORD_DEF)
) (
    input logic              clk,
    input logic              rst_n,
    gat_dbg_monitor_if.slave bus
);

    localparam int SEL_W     = rd_sel_w(NUM_CH, NUM_CAP);
    localparam int IDX_W     = $clog2(NUM_CAP + 1);
    localparam int W_SLOT0   = W_CNT0 + NUM_CH;

    logic [NUM_CH-1:0] vld_seen;
    logic [NUM_CH-1:0] rdy_seen;
    logic [NUM_CH-1:0] ovf;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [CNT_W-1:0]  cycle_cnt;

    dbg_state_e        state;
    dbg_state_e        state_nxt;
    logic [IDX_W-1:0]  cap_idx;
    logic [DBG_W-1:0]  slot [NUM_CAP];
    logic [ADDR_W-1:0] addr_diff;
    logic              trig;
    logic              cap_en;

    logic [DBG_W-1:0]  flags_word;
    logic [DBG_W-1:0]  status_word;
    logic [DBG_W-1:0]  rd_word;

    // ---------------- statistics ----------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        gat_dbg_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (bus.vld_i[g]),
            .clr   (bus.clr_i),
            .cnt   (cnt[g]),
            .ovf   (ovf[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_seen  <= '0;
            rdy_seen  <= '0;
            cycle_cnt <= '0;
        end else if (bus.clr_i) begin
            vld_seen  <= '0;
            rdy_seen  <= '0;
            cycle_cnt <= '0;
        end else begin
            vld_seen  <= vld_seen | bus.vld_i;
            rdy_seen  <= rdy_seen | bus.rdy_i;
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    // ---------------- capture FSM ----------------
    assign addr_diff = bus.trig_addr_i ^ bus.trig_match_i;
    assign trig      = ~|addr_diff && bus.trig_qual_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.arm_i) begin
            state_nxt = ST_ARMED;
        end else if (state == ST_ARMED && trig
                     && cap_idx == IDX_W'(NUM_CAP - 1)) begin
            state_nxt = ST_DONE;
        end
    end

    // arm_i takes priority, so a trigger in the arming cycle is dropped.
    always_comb begin
        cap_en          = (state == ST_ARMED) && trig && !bus.arm_i;
        bus.cap_done_o  = (state == ST_DONE);
        bus.fsm_state_o = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_idx <= '0;
            for (int k = 0; k < NUM_CAP; k++) slot[k] <= '0;
        end else begin
            if (bus.arm_i)   cap_idx <= '0;
            else if (cap_en) cap_idx <= cap_idx + IDX_W'(1);
            for (int k = 0; k < NUM_CAP; k++) begin
                if (cap_en && cap_idx == IDX_W'(k)) slot[k] <= bus.cap_data_i;
            end
        end
    end

    // ---------------- readout ----------------
    always_comb begin
        flags_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            flags_word[2*i]   = vld_seen[i];
            flags_word[2*i+1] = rdy_seen[i];
        end
        status_word              = '0;
        status_word[1:0]         = state;
        status_word[7:2]         = 6'(cap_idx);
        status_word[16 +: NUM_CH] = ovf;
    end

    always_comb begin
        rd_word = DBG_W'(DEAD_WORD);
        if (bus.rd_sel_i == SEL_W'(W_SIG))    rd_word = SIG_WORD;
        if (bus.rd_sel_i == SEL_W'(W_FLAGS))  rd_word = flags_word;
        if (bus.rd_sel_i == SEL_W'(W_STATUS)) rd_word = status_word;
        if (bus.rd_sel_i == SEL_W'(W_CYCLE))  rd_word = DBG_W'(cycle_cnt);
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_sel_i == SEL_W'(W_CNT0 + i)) rd_word = DBG_W'(cnt[i]);
        end
        for (int k = 0; k < NUM_CAP; k++) begin
            if (bus.rd_sel_i == SEL_W'(W_SLOT0 + k)) rd_word = slot[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rd_data_o <= '0;
        else        bus.rd_data_o <= rd_word;
    end

endmodule

// File: tb/tb_gat_dbg_monitor.sv
// -----------------------------------------------------------------------------
// tb_gat_dbg_monitor
// Directed bench for gat_dbg_monitor (NUM_CH=8, NUM_CAP=2, CNT_W=4).
// The driver issues readout selects and pushes the hand-computed expected
// {cap_done_o, rd_data_o} into exp_q; the monitor pops and compares one
// cycle later, when the registered readout presents the word.
// -----------------------------------------------------------------------------
module tb_gat_dbg_monitor;
    import gat_dbg_pkg::*;

    localparam int NUM_CH  = 8;
    localparam int NUM_CAP = 2;
    localparam int CNT_W   = 4;
    localparam int ADDR_W  = 14;
    localparam int DBG_W   = 32;
    localparam int SEL_W   = rd_sel_w(NUM_CH, NUM_CAP);

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gat_dbg_monitor_if #(
        .NUM_CH(NUM_CH), .NUM_CAP(NUM_CAP), .ADDR_W(ADDR_W), .DBG_W(DBG_W)
    ) bus ();

    gat_dbg_monitor #(
        .NUM_CH(NUM_CH), .NUM_CAP(NUM_CAP), .CNT_W(CNT_W),
        .ADDR_W(ADDR_W), .DBG_W(DBG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [DBG_W:0] exp_q [$];
    string          name_q [$];
    logic           rd_req = 1'b0;
    int             checks = 0;
    int             errors = 0;

    task automatic check(input string name, input logic [DBG_W:0] act,
                         input logic [DBG_W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got done=%0b data=0x%08h, expected done=%0b data=0x%08h",
                     name, act[DBG_W], act[DBG_W-1:0], exp[DBG_W], exp[DBG_W-1:0]);
        end
    endtask

    initial begin : monitor
        logic [DBG_W:0] e;
        string          n;
        forever begin
            @(posedge clk);
            if (rd_req) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got data=0x%08h, expected no pending read",
                             bus.rd_data_o);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check(n, {bus.cap_done_o, bus.rd_data_o}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic read_word(input int sel, input logic [DBG_W-1:0] exp_data,
                             input logic exp_done, input string name);
        bus.rd_sel_i = SEL_W'(sel);
        rd_req       = 1'b1;
        exp_q.push_back({exp_done, exp_data});
        name_q.push_back(name);
        step();
        rd_req = 1'b0;
    endtask

    task automatic trig_cycle(input logic [DBG_W-1:0] data, input logic arm);
        bus.trig_addr_i = ADDR_W'(10);
        bus.trig_qual_i = 1'b1;
        bus.cap_data_i  = data;
        bus.arm_i       = arm;
        step();
        bus.trig_addr_i = '0;
        bus.trig_qual_i = 1'b0;
        bus.arm_i       = 1'b0;
    endtask

    task automatic pulse_arm();
        bus.arm_i = 1'b1;
        step();
        bus.arm_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        bus.vld_i        = '0;
        bus.rdy_i        = '0;
        bus.clr_i        = 1'b0;
        bus.arm_i        = 1'b0;
        bus.trig_match_i = ADDR_W'(10);
        bus.trig_addr_i  = '0;
        bus.trig_qual_i  = 1'b0;
        bus.cap_data_i   = '0;
        bus.rd_sel_i     = '0;

        repeat (3) step();
        check("reset_outputs", {bus.cap_done_o, bus.rd_data_o}, '0);
        rst_n = 1'b1;

        // signature and reset-state words
        read_word(0,  32'h0C47_0002, 1'b0, "sig_word");
        read_word(1,  32'h0,         1'b0, "flags_reset");
        read_word(2,  32'h0,         1'b0, "status_reset");
        read_word(12, 32'h0,         1'b0, "slot0_reset");

        // vld[2] five cycles, rdy[5] one cycle
        bus.vld_i[2] = 1'b1;
        bus.rdy_i[5] = 1'b1;
        step();
        bus.rdy_i[5] = 1'b0;
        repeat (4) step();
        bus.vld_i[2] = 1'b0;
        read_word(1, 32'h0000_0810, 1'b0, "flags_vld2_rdy5");
        read_word(6, 32'd5,         1'b0, "cnt2_five");
        read_word(9, 32'd0,         1'b0, "cnt5_rdy_only");
        read_word(4, 32'd0,         1'b0, "cnt0_idle");

        // saturation of the 4-bit counter
        bus.vld_i[0] = 1'b1;
        repeat (20) step();
        bus.vld_i[0] = 1'b0;
        read_word(4, 32'd15,        1'b0, "cnt0_saturated");
        read_word(2, 32'h0001_0000, 1'b0, "status_ovf0");
        read_word(1, 32'h0000_0811, 1'b0, "flags_plus_vld0");
        read_word(6, 32'd5,         1'b0, "cnt2_held");

        // clear, then cycle counter start value and wrap
        bus.clr_i = 1'b1;
        step();
        bus.clr_i = 1'b0;
        read_word(3, 32'd0, 1'b0, "cycle_after_clr");
        read_word(3, 32'd1, 1'b0, "cycle_increment");
        read_word(4, 32'd0, 1'b0, "cnt0_cleared");
        read_word(2, 32'd0, 1'b0, "status_ovf_cleared");
        read_word(1, 32'd0, 1'b0, "flags_cleared");
        repeat (10) step();
        read_word(3, 32'd15, 1'b0, "cycle_max");
        read_word(3, 32'd0,  1'b0, "cycle_wrap");

        // trigger while IDLE is ignored
        trig_cycle(32'h99, 1'b0);
        read_word(2,  32'd0, 1'b0, "status_idle_trig");
        read_word(12, 32'd0, 1'b0, "slot0_idle_trig");

        // two separated triggers fill both slots, third ignored in DONE
        pulse_arm();
        read_word(2, 32'h1, 1'b0, "status_armed");
        trig_cycle(32'hAA, 1'b0);
        read_word(2, 32'h5, 1'b0, "status_one_cap");
        trig_cycle(32'hBB, 1'b0);
        read_word(12, 32'hAA, 1'b1, "slot0_aa");
        read_word(13, 32'hBB, 1'b1, "slot1_bb");
        read_word(2,  32'hA,  1'b1, "status_done");
        trig_cycle(32'hCC, 1'b0);
        read_word(12, 32'hAA, 1'b1, "slot0_after_done_trig");
        read_word(13, 32'hBB, 1'b1, "slot1_after_done_trig");

        // arm from DONE with a trigger in the same cycle
        trig_cycle(32'h11, 1'b1);
        read_word(2,  32'h1,  1'b0, "status_arm_trig_dropped");
        read_word(12, 32'hAA, 1'b0, "slot0_kept_on_arm");
        // consecutive trigger cycles fill consecutive slots
        trig_cycle(32'h21, 1'b0);
        trig_cycle(32'h22, 1'b0);
        read_word(12, 32'h21, 1'b1, "slot0_back_to_back");
        read_word(13, 32'h22, 1'b1, "slot1_back_to_back");
        pulse_arm();
        read_word(2, 32'h1, 1'b0, "status_rearm_from_done");

        // asynchronous reset in the middle of a capture
        trig_cycle(32'h55, 1'b0);
        read_word(2, 32'h5, 1'b0, "status_mid_capture");
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {bus.cap_done_o, bus.rd_data_o}, '0);
        step();
        rst_n = 1'b1;
        read_word(12, 32'd0, 1'b0, "slot0_after_reset");
        read_word(13, 32'd0, 1'b0, "slot1_after_reset");
        read_word(2,  32'd0, 1'b0, "status_after_reset");

        // clr_i beats a same-cycle event
        bus.vld_i[3] = 1'b1;
        step();
        bus.vld_i[3] = 1'b0;
        read_word(1, 32'h40, 1'b0, "flags_vld3");
        read_word(7, 32'd1,  1'b0, "cnt3_one");
        bus.clr_i    = 1'b1;
        bus.vld_i[1] = 1'b1;
        step();
        bus.clr_i    = 1'b0;
        bus.vld_i[1] = 1'b0;
        read_word(5, 32'd0, 1'b0, "cnt1_clr_wins");
        read_word(1, 32'd0, 1'b0, "flags_clr_wins");
        read_word(7, 32'd0, 1'b0, "cnt3_cleared");

        // out-of-range selects
        read_word(14, 32'hDEAD_BEEF, 1'b0, "sel14_dead");
        read_word(15, 32'hDEAD_BEEF, 1'b0, "sel15_dead");

        // bounded drain of the scoreboard
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending reads, expected 0",
                     exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
